// File: rtl/lcd_bus_receiver.sv
`timescale 1ns / 1ps
// 8080-style LCD write-bus receiver: synchronizes the panel bus, decodes
// CASET/PASET/RAMWR and emits RGB565 pixels with their panel coordinates.
//
// state    | meaning
// ST_IDLE  | no active command, data bytes ignored
// ST_CASET | collecting column window parameters
// ST_PASET | collecting page window parameters
// ST_RAMWR | streaming pixel bytes into the window

module lcd_bus_receiver #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_cs,
  input  logic        lcd_rs,
  input  logic        lcd_wr,
  input  logic [7:0]  lcd_d,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_data,
  output logic        frame_start
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CASET = 2'd1;
  localparam logic [1:0] ST_PASET = 2'd2;
  localparam logic [1:0] ST_RAMWR = 2'd3;

  localparam logic [15:0] EC_RST = 16'(WIDTH - 1);
  localparam logic [15:0] EP_RST = 16'(HEIGHT - 1);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [7:0] CMD_RAMWC = 8'h3C;

  logic       cs_s1, cs_s2;
  logic       rs_s1, rs_s2;
  logic       wr_s1, wr_s2, wr_s3;
  logic [7:0] d_s1, d_s2;
  logic [1:0] sync_vld;
  logic       armed;
  logic       cap;

  logic [1:0]  state;
  logic [2:0]  param_cnt;
  logic [7:0]  param_b1, param_b2, param_b3;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] x, y;
  logic [15:0] next_x, next_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      rs_s1    <= 1'b0;
      rs_s2    <= 1'b0;
      wr_s1    <= 1'b0;
      wr_s2    <= 1'b0;
      wr_s3    <= 1'b0;
      d_s1     <= 8'h00;
      d_s2     <= 8'h00;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      cs_s1    <= lcd_cs;
      cs_s2    <= cs_s1;
      rs_s1    <= lcd_rs;
      rs_s2    <= rs_s1;
      wr_s1    <= lcd_wr;
      wr_s2    <= wr_s1;
      wr_s3    <= wr_s2;
      d_s1     <= lcd_d;
      d_s2     <= d_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      // wr must be seen low once the pipeline holds real samples, so a
      // strobe already high at reset release is not mistaken for an edge
      armed    <= armed | (sync_vld[1] & ~wr_s2);
    end
  end

  assign cap = armed & wr_s2 & ~wr_s3 & ~cs_s2;

  always_comb begin
    next_x = x + 16'd1;
    next_y = y;
    if (x == ec) begin
      next_x = sc;
      next_y = (y == ep) ? sp : (y + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      param_cnt   <= 3'd0;
      param_b1    <= 8'h00;
      param_b2    <= 8'h00;
      param_b3    <= 8'h00;
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
      sc          <= 16'h0000;
      ec          <= EC_RST;
      sp          <= 16'h0000;
      ep          <= EP_RST;
      x           <= 16'h0000;
      y           <= 16'h0000;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'h00;
      pix_valid   <= 1'b0;
      pix_x       <= 16'h0000;
      pix_y       <= 16'h0000;
      pix_data    <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (cap) begin
        if (!rs_s2) begin
          cmd_valid <= 1'b1;
          cmd_byte  <= d_s2;
          param_cnt <= 3'd0;
          phase     <= 1'b0;
          case (d_s2)
            CMD_CASET: state <= ST_CASET;
            CMD_PASET: state <= ST_PASET;
            CMD_RAMWR: begin
              state       <= ST_RAMWR;
              x           <= sc;
              y           <= sp;
              frame_start <= 1'b1;
            end
            CMD_RAMWC: state <= ST_RAMWR;
            default:   state <= ST_IDLE;
          endcase
        end else begin
          case (state)
            ST_CASET, ST_PASET: begin
              if (param_cnt != 3'd4) begin
                param_cnt <= param_cnt + 3'd1;
                case (param_cnt)
                  3'd0: param_b1 <= d_s2;
                  3'd1: param_b2 <= d_s2;
                  3'd2: param_b3 <= d_s2;
                  default: begin
                    if (state == ST_CASET) begin
                      sc <= {param_b1, param_b2};
                      ec <= {param_b3, d_s2};
                    end else begin
                      sp <= {param_b1, param_b2};
                      ep <= {param_b3, d_s2};
                    end
                  end
                endcase
              end
            end
            ST_RAMWR: begin
              if (!phase) begin
                hi_byte <= d_s2;
                phase   <= 1'b1;
              end else begin
                phase     <= 1'b0;
                pix_valid <= 1'b1;
                pix_x     <= x;
                pix_y     <= y;
                pix_data  <= {hi_byte, d_s2};
                x         <= next_x;
                y         <= next_y;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
